// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: handshake bundle between the frontend, the fetch buffer
// and the decode stage. The buffer attaches through the slave modport; the
// environment (frontend plus decode) attaches through the master modport.
interface fetch_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  // Frontend -> buffer
  logic                     in_valid;
  logic [31:0]              in_pc;
  logic [31:0]              in_instr;
  logic                     in_misaligned;
  logic                     flush;
  // Buffer -> frontend
  logic                     in_ready;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   count;
  // Buffer -> decode
  logic                     out_valid;
  logic [31:0]              out_pc;
  logic [31:0]              out_instr;
  logic                     out_misaligned;
  // Decode -> buffer
  logic                     out_ready;

  modport master (
    output in_valid, in_pc, in_instr, in_misaligned, flush, out_ready,
    input  in_ready, overflow, count, out_valid, out_pc, out_instr, out_misaligned
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_misaligned, flush, out_ready,
    output in_ready, overflow, count, out_valid, out_pc, out_instr, out_misaligned
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: small circular instruction queue between the frontend and
// decode. Holds {pc, instr, misaligned} entries, presents the oldest one under
// a valid/ready handshake, empties in one cycle on flush and flags sticky
// overflow when a push is attempted while full.
// Optional feature: define FETCH_BUF_BYPASS_EN to let an incoming instruction
// reach the outputs combinationally while the buffer is empty.
module fetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000033
) (
  input logic           clk,
  input logic           nrst,
  fetch_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  state_e        state_q, state_d;

  logic          full;
  logic          empty;
  logic          bypass;
  logic          push;
  logic          pop;

  // Handshake qualifiers; full/empty come from the registered state only so
  // out_ready never reaches in_ready combinationally.
  always_comb begin
    full  = (state_q == ST_FULL);
    empty = (state_q == ST_EMPTY);
`ifdef FETCH_BUF_BYPASS_EN
    bypass = empty && bus.in_valid && !bus.flush;
`else
    bypass = 1'b0;
`endif
    // A bypassed instruction taken by decode the same cycle is never stored.
    push = bus.in_valid && !full && !bus.flush && !(bypass && bus.out_ready);
    // Pop only consumes stored entries; a bypassed head is not in storage.
    pop  = !empty && bus.out_ready && !bus.flush;
  end

  // Next-state computation for pointers, occupancy, overflow and FSM state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.in_valid && full) overflow_d = 1'b1;
    end
    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PARTIAL;
    end
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_EMPTY;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // Entry storage; contents are deliberately left untouched by reset/flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: bus.in_pc, instr: bus.in_instr,
                           misaligned: bus.in_misaligned};
    end
  end

  // Head presentation: stored head when occupied, optional bypass when empty,
  // otherwise a harmless NOP with zero pc.
  always_comb begin
    bus.out_valid      = 1'b0;
    bus.out_pc         = '0;
    bus.out_instr      = NOP_INSTR;
    bus.out_misaligned = 1'b0;
    if (!empty) begin
      bus.out_valid      = 1'b1;
      bus.out_pc         = mem_q[rd_ptr_q].pc;
      bus.out_instr      = mem_q[rd_ptr_q].instr;
      bus.out_misaligned = mem_q[rd_ptr_q].misaligned;
    end else if (bypass) begin
      bus.out_valid      = 1'b1;
      bus.out_pc         = bus.in_pc;
      bus.out_instr      = bus.in_instr;
      bus.out_misaligned = bus.in_misaligned;
    end
  end

  // Frontend-facing status.
  always_comb begin
    bus.in_ready = !full;
    bus.count    = count_q;
    bus.overflow = overflow_q;
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer (DEPTH=4).
module tb_fetch_buffer;
  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;

  fetch_buffer_if #(.DEPTH(4)) bus ();

  fetch_buffer #(.DEPTH(4), .NOP_INSTR(32'h00000033)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side encoding of the instruction word and flag tied to each pc.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h00000F13;
  endfunction

  function automatic logic mis_of(input logic [31:0] pc);
    return pc[2];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] pc);
    bus.in_valid      = v;
    bus.in_pc         = pc;
    bus.in_instr      = instr_of(pc);
    bus.in_misaligned = mis_of(pc);
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_instr !== 32'h00000033) begin
      n_fail++; $display("FAIL reset_out_instr got=%h exp=00000033", bus.out_instr);
    end
    n_checks++;
    if (bus.count !== 3'd0 || bus.in_ready !== 1'b1 || bus.overflow !== 1'b0 || bus.out_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_status got count=%0d in_ready=%0b ovf=%0b pc=%h exp 0/1/0/0",
                         bus.count, bus.in_ready, bus.overflow, bus.out_pc);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    step();
    $display("reset: done");
  endtask

  task automatic test_latency();
    drive_in(1'b1, 32'h40000020);
    bus.out_ready = 1'b1;
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40000020 || bus.out_instr !== instr_of(32'h40000020)) begin
      n_fail++; $display("FAIL bypass_same_cycle got valid=%0b pc=%h instr=%h exp 1/40000020/%h",
                         bus.out_valid, bus.out_pc, bus.out_instr, instr_of(32'h40000020));
    end
    step();
    drive_in(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_not_stored got count=%0d valid=%0b exp 0/0", bus.count, bus.out_valid);
    end
    $display("bypass: pc=40000020 consumed same cycle");
`else
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h00000033) begin
      n_fail++; $display("FAIL latency_not_same_cycle got valid=%0b instr=%h exp 0/00000033",
                         bus.out_valid, bus.out_instr);
    end
    step();
    drive_in(1'b0, 32'h0);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40000020 || bus.count !== 3'd1) begin
      n_fail++; $display("FAIL latency_one_cycle got valid=%0b pc=%h count=%0d exp 1/40000020/1",
                         bus.out_valid, bus.out_pc, bus.count);
    end
    step();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_pop got count=%0d valid=%0b exp 0/0", bus.count, bus.out_valid);
    end
    $display("latency: pc=40000020 visible one cycle after push");
`endif
  endtask

  task automatic test_fill_overflow();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 32'h40000000 + 32'(4 * i));
      step();
      $display("fill: push pc=%h count=%0d", 32'h40000000 + 32'(4 * i), bus.count);
    end
    n_checks++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_status got count=%0d in_ready=%0b ovf=%0b exp 4/0/0",
                         bus.count, bus.in_ready, bus.overflow);
    end
    drive_in(1'b1, 32'h40000010);
    step();
    drive_in(1'b0, 32'h0);
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin
      n_fail++; $display("FAIL overflow_push got ovf=%0b count=%0d exp 1/4", bus.overflow, bus.count);
    end
    $display("fill: 5th push pc=40000010 dropped, overflow=%0b", bus.overflow);
  endtask

  task automatic test_drain();
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h40000000 + 32'(4 * i);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== instr_of(exp_pc)
          || bus.out_misaligned !== mis_of(exp_pc)) begin
        n_fail++; $display("FAIL drain_head[%0d] got valid=%0b pc=%h instr=%h mis=%0b exp pc=%h instr=%h mis=%0b",
                           i, bus.out_valid, bus.out_pc, bus.out_instr, bus.out_misaligned,
                           exp_pc, instr_of(exp_pc), mis_of(exp_pc));
      end
      $display("drain: pop pc=%h", bus.out_pc);
      step();
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h00000033) begin
      n_fail++; $display("FAIL drain_empty got valid=%0b count=%0d pc=%h instr=%h exp 0/0/0/00000033",
                         bus.out_valid, bus.count, bus.out_pc, bus.out_instr);
    end
    n_checks++;
    if (bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_sticky got=%0b exp=1", bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_in(1'b1, 32'h40000100 + 32'(4 * i));
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] exp_head;
      exp_head = 32'h40000100 + 32'(4 * i);
      drive_in(1'b1, 32'h40000100 + 32'(4 * (i + 2)));
      #1;
      n_checks++;
      if (bus.out_pc !== exp_head || bus.count !== 3'd2 || bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b[%0d] got pc=%h count=%0d valid=%0b exp pc=%h count=2 valid=1",
                           i, bus.out_pc, bus.count, bus.out_valid, exp_head);
      end
      $display("b2b: push pc=%h pop pc=%h count=%0d", bus.in_pc, bus.out_pc, bus.count);
      step();
    end
    drive_in(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.count !== 3'd2 || bus.out_pc !== 32'h40000128) begin
      n_fail++; $display("FAIL b2b_end got count=%0d pc=%h exp 2/40000128", bus.count, bus.out_pc);
    end
  endtask

  task automatic test_flush();
    drive_in(1'b1, 32'h40000300);
    step();
    n_checks++;
    if (bus.count !== 3'd3) begin
      n_fail++; $display("FAIL flush_pre_count got=%0d exp=3", bus.count);
    end
    drive_in(1'b1, 32'h40000F00);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 32'h0);
    n_checks++;
    if (bus.count !== 3'd0 || bus.overflow !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state got count=%0d ovf=%0b valid=%0b in_ready=%0b exp 0/0/0/1",
                         bus.count, bus.overflow, bus.out_valid, bus.in_ready);
    end
    $display("flush: count=%0d overflow=%0b", bus.count, bus.overflow);
    drive_in(1'b1, 32'h40000200);
    step();
    drive_in(1'b0, 32'h0);
    n_checks++;
    if (bus.out_pc !== 32'h40000200 || bus.count !== 3'd1) begin
      n_fail++; $display("FAIL flush_discard got pc=%h count=%0d exp 40000200/1", bus.out_pc, bus.count);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_after_pop got count=%0d valid=%0b exp 0/0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_in(1'b1, 32'h40000400 + 32'(4 * i));
      step();
    end
    drive_in(1'b0, 32'h0);
    #2;
    nrst = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_instr !== 32'h00000033) begin
      n_fail++; $display("FAIL async_reset got count=%0d valid=%0b in_ready=%0b instr=%h exp 0/0/1/00000033",
                         bus.count, bus.out_valid, bus.in_ready, bus.out_instr);
    end
    step();
    drive_in(1'b1, 32'h40000500);
    #2;
    nrst = 1'b1;
    step();
    drive_in(1'b0, 32'h0);
    n_checks++;
    if (bus.count !== 3'd1 || bus.out_pc !== 32'h40000500) begin
      n_fail++; $display("FAIL reset_first_push got count=%0d pc=%h exp 1/40000500", bus.count, bus.out_pc);
    end
    $display("async_reset: first push after release pc=%h", bus.out_pc);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    nrst      = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 32'h0);
    test_reset();
    test_latency();
    test_fill_overflow();
    test_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Decoupling instruction queue between `frontend_stage` and the decode stage. It captures every fetched instruction the frontend produces, together with its pc and misaligned flag, into a small circular FIFO. It presents the oldest entry to decode under a valid/ready handshake, so a decode-side stall no longer forces a refetch through the L1.5. It empties in one cycle on a redirect or kill, and reports back-pressure and overflow to the frontend.

## Interface
Parameters:
- `DEPTH`, 4: entry count; power of two, ≥2.
- `NOP_INSTR`, 32'h00000033: instruction driven on `out_instr` whenever `out_valid`=0.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: frontend presents a real fetched instruction this cycle.
- `in_pc` in 32: pc of the incoming instruction (frontend `pc2`).
- `in_instr` in 32: byte-swapped instruction word (frontend `instr2`).
- `in_misaligned` in 1: instruction-address-misaligned flag for this entry.
- `in_ready` out 1: buffer can accept a push; equals !full, registered-state only.
- `flush` in 1: kill/redirect/exception; discards all entries.
- `out_valid` out 1: head entry valid.
- `out_pc` out 32: head pc.
- `out_instr` out 32: head instruction.
- `out_misaligned` out 1: head misaligned flag.
- `out_ready` in 1: decode consumes the head this cycle.
- `count` out $clog2(DEPTH)+1: number of occupied entries.
- `overflow` out 1: sticky; a push was attempted while full.

## Operation
- Storage: `DEPTH` entries of {pc, instr, misaligned}, indexed by `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits. Pointers wrap modulo `DEPTH` (natural binary wrap). `count` is tracked separately.
- Push: `in_valid && in_ready && !flush`. Writes the entry at `wr_ptr` and increments `wr_ptr`.
- Pop: `out_valid && out_ready && !flush`. Increments `rd_ptr`.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged; both pointers advance.
- Full: `count`==`DEPTH`, so `in_ready`=0. A push attempted while full is dropped and sets `overflow`.
- Empty: `count`==0, so `out_valid`=0. Outputs then read `out_pc`=0, `out_instr`=`NOP_INSTR`, `out_misaligned`=0.
- Flush has highest priority. On the next edge:
  - `count`, `wr_ptr` and `rd_ptr` go to 0.
  - `overflow` clears.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle is ignored.
  - Entry contents are not cleared.
- `overflow` clears only on reset or flush.
- States, derived from `count`: EMPTY (0), PARTIAL (1..DEPTH−1), FULL (DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push-only when `count`=DEPTH−1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop-only when `count`=1.
  - Any state→EMPTY on flush.
- Reset values: `count`=0, `out_valid`=0, `in_ready`=1, `out_pc`=0, `out_instr`=`NOP_INSTR`, `out_misaligned`=0, `overflow`=0, both pointers 0.

## Timing
- Push-to-`out_valid` latency: 1 cycle; the entry is visible the cycle after the push edge.
- `in_ready`, `out_valid` and `count` depend only on registered state. There is no combinational path from `out_ready` to `in_ready`.
- Head outputs are a mux of registered storage at `rd_ptr`. They are stable while `out_valid` && !`out_ready`.
- Order is strictly FIFO. The `in_pc` sequence equals the `out_pc` sequence between flushes.
- Asynchronous reset mid-operation: all state returns to reset values immediately and in-flight entries are lost. The first push is accepted on the first edge after `nrst` rises.

## Configuration
- `FETCH_BUF_BYPASS_EN`
  - Defined: when the buffer is empty, `in_valid` is high and `flush` is low, the input drives the outputs combinationally in the same cycle (`out_valid`=1, `out_pc`=`in_pc`, and so on). If `out_ready` is also high, the entry is consumed without being written, and `count` stays 0.
  - Not defined: push-to-`out_valid` latency is always 1 cycle and the outputs are purely registered-state driven.

## Test plan
- Reset then idle: `nrst` low → `out_valid`=0, `out_instr`=32'h33, `count`=0, `in_ready`=1.
- Fill to full with `out_ready`=0, pushing pcs 0x40000000, 0x40000004, 0x40000008, 0x4000000C:
  - Expect `count`=4 and `in_ready`=0.
  - A 5th push (pc 0x40000010) sets `overflow`=1, and `count` stays 4.
- Drain in order: from full, `out_ready`=1 for 4 cycles → `out_pc` reads 0x40000000, 0x40000004, 0x40000008, 0x4000000C, then `out_valid`=0.
- Simultaneous push and pop at `count`=2, sustained for 10 cycles with incrementing pcs:
  - `count` stays 2.
  - Pointers wrap at least twice.
  - Order is preserved.
- Flush with push in the same cycle, at `count`=3: next cycle `count`=0, `overflow`=0, `out_valid`=0. The pushed pc never appears on `out_pc`.
- Bypass, only with `FETCH_BUF_BYPASS_EN`: empty buffer, `in_valid`=1, `in_pc`=0x40000020, `out_ready`=1 → same cycle `out_valid`=1 and `out_pc`=0x40000020. Next cycle `count`=0.
